// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache. Hits return the word
// combinationally; misses stall the CPU while a 16-byte block is fetched
// from instruction memory and installed in the indexed line.
module instr_cache #(
  parameter int ADDR_BITS  = 10,
  parameter int INDEX_BITS = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC,
  output logic [31:0]          INSTRUCTION,
  output logic                 BUSYWAIT,
  output logic                 MEM_READ,
  output logic [ADDR_BITS-5:0] MEM_ADDRESS,
  input  logic [127:0]         MEM_READDATA,
  input  logic                 MEM_BUSYWAIT
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 4;
  localparam int BLK_BITS = ADDR_BITS - 4;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

  state_t                state_q, state_d;
  logic [BLK_BITS-1:0]   fill_addr_q, fill_addr_d;
  logic [127:0]          fill_buf_q, fill_buf_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];

  logic [1:0]            pc_off;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [3:0][31:0]      line_w;
  logic                  hit;
  logic                  unused_pc;

  // PC bits above the address range alias; the byte lane bits are ignored.
  assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

  assign pc_off   = PC[3:2];
  assign pc_idx   = PC[INDEX_BITS+3:4];
  assign pc_tag   = PC[ADDR_BITS-1:INDEX_BITS+4];
  assign fill_idx = fill_addr_q[INDEX_BITS-1:0];
  assign fill_tag = fill_addr_q[BLK_BITS-1:INDEX_BITS];
  assign line_w   = data_q[pc_idx];

  // Lookup only counts while idle, so a PC change mid-fill cannot hit early.
  assign hit = (state_q == S_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  // State, fill registers and valid bits; reset aborts any fill in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      fill_addr_q <= '0;
      fill_buf_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      fill_buf_q  <= fill_buf_d;
      if (state_q == S_UPDATE) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Line tag/data storage is not cleared; valid bits gate its use.
  always_ff @(posedge CLK) begin
    if (state_q == S_UPDATE && !RESET) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_buf_q;
    end
  end

  // Next state: latch the miss address once, then ride out the memory handshake.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_buf_d  = fill_buf_q;
    case (state_q)
      S_IDLE: begin
        if (!hit) begin
          state_d     = S_MEM_READ;
          fill_addr_d = {pc_tag, pc_idx};
        end
      end
      S_MEM_READ: begin
        if (!MEM_BUSYWAIT) begin
          fill_buf_d = MEM_READDATA;
          state_d    = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: the fill address doubles as the memory address and holds between fills.
  always_comb begin
    MEM_READ    = (state_q == S_MEM_READ);
    MEM_ADDRESS = fill_addr_q;
    BUSYWAIT    = !RESET && !hit;
    INSTRUCTION = hit ? line_w[pc_off] : 32'h0;
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache with a busy-wait instruction memory model.
// Block b word k holds 32'h1000_0000*(k+1) + b.
module tb_instr_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [31:0]  PC = 32'h0;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int checks = 0;
  int failures = 0;
  int wait_n = 0;
  int rd_cnt = 0;

  instr_cache #(.ADDR_BITS(10), .INDEX_BITS(3)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [127:0] blk_data(input logic [5:0] b);
    logic [3:0][31:0] w;
    for (int k = 0; k < 4; k++) w[k] = 32'h1000_0000 * (k + 1) + {26'h0, b};
    return w;
  endfunction

  // Memory: busy for wait_n cycles of each request, then ready.
  assign MEM_READDATA = blk_data(MEM_ADDRESS);
  assign MEM_BUSYWAIT = (rd_cnt < wait_n);
  always @(posedge CLK) rd_cnt <= (MEM_READ === 1'b1) ? rd_cnt + 1 : 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents pc in the current (idle) cycle and follows the resulting miss.
  task automatic miss_fill(input string tag, input logic [31:0] pc, input logic [5:0] blk,
                           input int n, input logic [31:0] word);
    int cyc;
    int mr;
    PC = pc;
    #1;
    chk({tag, "_miss_busy"}, {31'h0, BUSYWAIT}, 32'h1);
    tick();
    cyc = 1;
    mr = (MEM_READ === 1'b1) ? 1 : 0;
    chk({tag, "_mread"}, {31'h0, MEM_READ}, 32'h1);
    chk({tag, "_maddr"}, {26'h0, MEM_ADDRESS}, {26'h0, blk});
    while (BUSYWAIT !== 1'b0 && cyc < 40) begin
      tick();
      cyc++;
      if (MEM_READ === 1'b1) mr++;
    end
    chk({tag, "_latency"}, cyc, n + 3);
    chk({tag, "_mread_cycles"}, mr, n + 1);
    chk({tag, "_instr"}, INSTRUCTION, word);
  endtask

  initial begin
    // Reset asserted mid-cycle takes effect without a clock edge.
    tick();
    #2 RESET = 1'b1;
    #1;
    chk("rst_mread", {31'h0, MEM_READ}, 32'h0);
    chk("rst_busy", {31'h0, BUSYWAIT}, 32'h0);
    chk("rst_instr", INSTRUCTION, 32'h0);
    chk("rst_maddr", {26'h0, MEM_ADDRESS}, 32'h0);
    tick();
    #3 RESET = 1'b0;

    // Cold miss at PC=0 with memory busy for 5 cycles.
    wait_n = 5;
    PC = 32'h0;
    #1;
    chk("cold_busy", {31'h0, BUSYWAIT}, 32'h1);
    chk("cold_idle_mread", {31'h0, MEM_READ}, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("cold_mread", {31'h0, MEM_READ}, 32'h1);
      chk("cold_maddr", {26'h0, MEM_ADDRESS}, 32'h0);
    end
    tick();
    chk("cold_upd_mread", {31'h0, MEM_READ}, 32'h0);
    chk("cold_upd_busy", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    chk("cold_done_busy", {31'h0, BUSYWAIT}, 32'h0);
    chk("cold_w0", INSTRUCTION, 32'h1000_0000);

    // Sequential hits within block 0.
    tick(); PC = 32'h4; #1;
    chk("seq_w1", INSTRUCTION, 32'h2000_0000);
    chk("seq_busy1", {31'h0, BUSYWAIT}, 32'h0);
    chk("seq_mread1", {31'h0, MEM_READ}, 32'h0);
    tick(); PC = 32'h8; #1;
    chk("seq_w2", INSTRUCTION, 32'h3000_0000);
    chk("seq_busy2", {31'h0, BUSYWAIT}, 32'h0);
    tick(); PC = 32'hC; #1;
    chk("seq_w3", INSTRUCTION, 32'h4000_0000);
    chk("seq_busy3", {31'h0, BUSYWAIT}, 32'h0);
    chk("seq_mread3", {31'h0, MEM_READ}, 32'h0);

    // Conflict eviction on index 0.
    wait_n = 2;
    tick();
    miss_fill("conf_080", 32'h080, 6'h08, 2, 32'h1000_0008);
    tick();
    miss_fill("conf_000", 32'h000, 6'h00, 2, 32'h1000_0000);

    // PC moves during the fill; the fill target must not follow it.
    wait_n = 3;
    tick(); PC = 32'h010; #1;
    chk("redir_miss", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    chk("redir_maddr1", {26'h0, MEM_ADDRESS}, 32'h01);
    PC = 32'h020;
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("redir_mread", {31'h0, MEM_READ}, 32'h1);
      chk("redir_maddr", {26'h0, MEM_ADDRESS}, 32'h01);
    end
    tick();
    chk("redir_upd_mread", {31'h0, MEM_READ}, 32'h0);
    chk("redir_upd_busy", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    chk("redir_idle_busy", {31'h0, BUSYWAIT}, 32'h1);
    chk("redir_idle_mread", {31'h0, MEM_READ}, 32'h0);
    tick();
    chk("redir2_mread", {31'h0, MEM_READ}, 32'h1);
    chk("redir2_maddr", {26'h0, MEM_ADDRESS}, 32'h02);
    begin
      int cyc = 0;
      while (BUSYWAIT !== 1'b0 && cyc < 40) begin tick(); cyc++; end
      chk("redir2_bound", {31'h0, BUSYWAIT}, 32'h0);
    end
    chk("redir2_instr", INSTRUCTION, 32'h1000_0002);
    tick(); PC = 32'h010; #1;
    chk("redir_line1_busy", {31'h0, BUSYWAIT}, 32'h0);
    chk("redir_line1_instr", INSTRUCTION, 32'h1000_0001);

    // Reset in the middle of a fill.
    wait_n = 4;
    tick(); PC = 32'h030; #1;
    chk("rfill_miss", {31'h0, BUSYWAIT}, 32'h1);
    tick();
    chk("rfill_mread", {31'h0, MEM_READ}, 32'h1);
    chk("rfill_maddr", {26'h0, MEM_ADDRESS}, 32'h03);
    #2 RESET = 1'b1;
    #1;
    chk("rfill_rst_mread", {31'h0, MEM_READ}, 32'h0);
    chk("rfill_rst_busy", {31'h0, BUSYWAIT}, 32'h0);
    chk("rfill_rst_instr", INSTRUCTION, 32'h0);
    chk("rfill_rst_maddr", {26'h0, MEM_ADDRESS}, 32'h0);
    tick();
    #3 RESET = 1'b0;

    // Zero-wait memory: line 3 misses again right after release.
    wait_n = 0;
    miss_fill("zw_030", 32'h030, 6'h03, 0, 32'h1000_0003);
    tick();
    miss_fill("zw_wrap", 32'h444, 6'h04, 0, 32'h2000_0004);
    tick(); PC = 32'h048; #1;
    chk("wrap_hit", INSTRUCTION, 32'h3000_0004);
    chk("wrap_hit_busy", {31'h0, BUSYWAIT}, 32'h0);
    tick(); PC = 32'h033; #1;
    chk("byte_lane_hit", INSTRUCTION, 32'h1000_0003);
    tick(); PC = 32'h000; #1;
    chk("rst_invalidated", {31'h0, BUSYWAIT}, 32'h1);
    chk("rst_invalid_instr", INSTRUCTION, 32'h0);
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
